// File: rtl/reg_file_pkg.sv
// Shared types, defaults and helpers for the multi-port register file.
// REG_FILE_BYPASS_EN (optional) enables same-cycle write-to-read forwarding.
package reg_file_pkg;

    localparam int unsigned XLEN_DEF  = 64;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned NRD_DEF   = 2;
    localparam int unsigned NWR_DEF   = 2;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    function automatic int unsigned addr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-facing bus of the register file: read, write, alloc and status.
// master drives requests (core side), slave is the register file.
interface reg_file_mp_if #(
    parameter int unsigned XLEN  = reg_file_pkg::XLEN_DEF,
    parameter int unsigned NREGS = reg_file_pkg::NREGS_DEF,
    parameter int unsigned NRD   = reg_file_pkg::NRD_DEF,
    parameter int unsigned NWR   = reg_file_pkg::NWR_DEF
);
    import reg_file_pkg::*;

    localparam int unsigned AW = addr_width(NREGS);

    logic                ready;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic [NREGS-1:0]    busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  ready, rd_data, rd_busy, busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output ready, rd_data, rd_busy, busy
    );

endinterface

// File: rtl/reg_file_sb.sv
// Busy scoreboard: writes clear a register's pending bit, alloc sets it.
// Alloc wins over a same-cycle write to the same register; bit 0 never sets.
module reg_file_sb #(
    parameter int unsigned NREGS = reg_file_pkg::NREGS_DEF,
    parameter int unsigned AW    = reg_file_pkg::addr_width(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             alloc_en,
    input  logic [AW-1:0]    alloc_addr,
    input  logic [NREGS-1:0] wr_clr,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy & ~wr_clr;
        if (alloc_en) begin
            busy_nxt[alloc_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with busy scoreboard and post-reset sequential clear.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching reads.
module reg_file_mp #(
    parameter int unsigned XLEN  = reg_file_pkg::XLEN_DEF,
    parameter int unsigned NREGS = reg_file_pkg::NREGS_DEF,
    parameter int unsigned NRD   = reg_file_pkg::NRD_DEF,
    parameter int unsigned NWR   = reg_file_pkg::NWR_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);
    import reg_file_pkg::*;

    localparam int unsigned AW = addr_width(NREGS);

    state_e           state;
    logic [AW:0]      cnt;
    logic [XLEN-1:0]  regs [NREGS];
    logic             run;
    logic [NREGS-1:0] wr_clr;
    logic [NREGS-1:0] busy;
    logic [AW-1:0]    ra;
    logic [AW-1:0]    wa;

    assign run       = (state == RUN);
    assign bus.ready = run;
    assign bus.busy  = busy;

    // Later ports are assigned last in the loop, so the highest index wins a collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            regs[cnt[AW-1:0]] <= '0;
            cnt <= cnt + (AW+1)'(1);
            if (cnt == (AW+1)'(NREGS - 1)) begin
                state <= RUN;
            end
        end else begin
            for (int unsigned j = 0; j < NWR; j++) begin
                if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] != '0)) begin
                    regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        wr_clr = '0;
        if (run) begin
            for (int unsigned j = 0; j < NWR; j++) begin
                if (bus.wr_en[j]) begin
                    wr_clr[bus.wr_addr[j*AW +: AW]] = 1'b1;
                end
            end
        end
    end

    reg_file_sb #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (!run),
        .alloc_en   (bus.alloc_en && run),
        .alloc_addr (bus.alloc_addr),
        .wr_clr     (wr_clr),
        .busy       (busy)
    );

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        ra = '0;
        wa = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            ra = bus.rd_addr[i*AW +: AW];
            if (run && (ra != '0)) begin
                bus.rd_data[i*XLEN +: XLEN] = regs[ra];
                bus.rd_busy[i] = busy[ra];
`ifdef REG_FILE_BYPASS_EN
                for (int unsigned j = 0; j < NWR; j++) begin
                    wa = bus.wr_addr[j*AW +: AW];
                    if (bus.wr_en[j] && (wa == ra)) begin
                        bus.rd_data[i*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
                        bus.rd_busy[i] = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus random traffic
// compared against an array-based reference model (honours REG_FILE_BYPASS_EN).
module tb_reg_file_mp;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NWR   = 2;
    localparam int unsigned AW    = 5;

    logic clk;
    logic rst_n;

    reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural contents, pending bits and remaining clear cycles.
    logic [XLEN-1:0]  m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    int               clear_left = NREGS;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int unsigned a;
        if (!rst_n) begin
            clear_left = NREGS;
            m_busy = '0;
            for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
        end else if (clear_left > 0) begin
            clear_left--;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                a = bus.wr_addr[j*AW +: AW];
                if (bus.wr_en[j]) begin
                    m_busy[a] = 1'b0;
                    if (a != 0) m_regs[a] = bus.wr_data[j*XLEN +: XLEN];
                end
            end
            if (bus.alloc_en && bus.alloc_addr != 0) m_busy[bus.alloc_addr] = 1'b1;
        end
    endtask

    task automatic exp_read(input int i, output logic [XLEN-1:0] d, output logic b);
        int unsigned a;
        a = bus.rd_addr[i*AW +: AW];
        d = '0;
        b = 1'b0;
        if (clear_left == 0 && a != 0) begin
            d = m_regs[a];
            b = m_busy[a];
`ifdef REG_FILE_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == a) begin
                    d = bus.wr_data[j*XLEN +: XLEN];
                    b = 1'b0;
                end
            end
`endif
        end
    endtask

    task automatic check_all(input string tag);
        logic [XLEN-1:0] d;
        logic            b;
        chk({tag, ".ready"}, 64'(bus.ready), 64'(clear_left == 0));
        chk({tag, ".busy"}, 64'(bus.busy), 64'(m_busy));
        for (int i = 0; i < NRD; i++) begin
            exp_read(i, d, b);
            chk($sformatf("%s.rd_data%0d", tag, i), bus.rd_data[i*XLEN +: XLEN], d);
            chk($sformatf("%s.rd_busy%0d", tag, i), 64'(bus.rd_busy[i]), 64'(b));
        end
    endtask

    task automatic tick(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus.wr_en = '0;
        bus.alloc_en = 1'b0;
    endtask

    task automatic set_wr(input int j, input int unsigned a, input logic [XLEN-1:0] d);
        bus.wr_en[j] = 1'b1;
        bus.wr_addr[j*AW +: AW] = AW'(a);
        bus.wr_data[j*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int i, input int unsigned a);
        bus.rd_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic randomize_inputs();
        bus.wr_en = NWR'($urandom);
        for (int j = 0; j < NWR; j++) begin
            bus.wr_addr[j*AW +: AW] = AW'($urandom_range(0, NREGS - 1));
            bus.wr_data[j*XLEN +: XLEN] = {$urandom, $urandom};
        end
        for (int i = 0; i < NRD; i++) begin
            bus.rd_addr[i*AW +: AW] = AW'($urandom_range(0, NREGS - 1));
        end
        bus.alloc_en = 1'($urandom);
        bus.alloc_addr = AW'($urandom_range(0, NREGS - 1));
    endtask

    task automatic count_to_ready(input string tag);
        int n;
        n = 0;
        while (!bus.ready && n < 100) begin
            randomize_inputs();
            tick(tag);
            n++;
        end
        chk({tag, ".ready_latency"}, 64'(n), 64'(NREGS));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.rd_addr = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.alloc_addr = '0;
        idle();
        @(posedge clk);
        model_edge();
        #1;

        // Reset held: everything quiet.
        for (int k = 0; k < 3; k++) tick("reset");
        chk("reset.ready_const", 64'(bus.ready), 64'(0));

        rst_n = 1'b1;
        count_to_ready("clear1");
        chk("ready_after_clear", 64'(bus.ready), 64'(1));

        // Two ports collide on x5; x0 write ignored.
        idle();
        set_wr(0, 5, 64'hAA);
        set_wr(1, 5, 64'hBB);
        tick("collide");
        idle();
        set_wr(0, 0, 64'h1);
        set_rd(0, 5);
        set_rd(1, 0);
        tick("x0_write");
        chk("x5_highest_port", bus.rd_data[0 +: XLEN], 64'hBB);
        chk("x0_reads_zero", bus.rd_data[XLEN +: XLEN], 64'h0);

        // Same-cycle read of x7 during write.
        idle();
        set_wr(0, 7, 64'h55);
        tick("x7_init");
        idle();
        set_wr(1, 7, 64'h1234);
        set_rd(0, 7);
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("x7_bypass", bus.rd_data[0 +: XLEN], 64'h1234);
`else
        chk("x7_old", bus.rd_data[0 +: XLEN], 64'h55);
`endif
        tick("x7_write");
        idle();
        tick("x7_after");
        chk("x7_new", bus.rd_data[0 +: XLEN], 64'h1234);

        // Scoreboard on x9.
        bus.alloc_en = 1'b1;
        bus.alloc_addr = AW'(9);
        tick("alloc9");
        #1;
        chk("busy9_set", 64'(bus.busy[9]), 64'(1));
        set_wr(0, 9, 64'h99);
        tick("alloc_wr9");
        idle();
        #1;
        chk("busy9_alloc_wins", 64'(bus.busy[9]), 64'(1));
        set_wr(1, 9, 64'h9A);
        tick("wr9");
        idle();
        #1;
        chk("busy9_cleared", 64'(bus.busy[9]), 64'(0));
        bus.alloc_addr = '0;
        bus.alloc_en = 1'b1;
        tick("alloc0");
        idle();
        #1;
        chk("busy0_zero", 64'(bus.busy[0]), 64'(0));

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            randomize_inputs();
            tick("rand");
        end

        // Reset while running with x3=0xFF.
        idle();
        set_wr(0, 3, 64'hFF);
        tick("x3_set");
        idle();
        set_rd(0, 3);
        tick("x3_read");
        chk("x3_ff", bus.rd_data[0 +: XLEN], 64'hFF);
        rst_n = 1'b0;
        tick("run_reset");
        rst_n = 1'b1;
        chk("ready_drops", 64'(bus.ready), 64'(0));
        count_to_ready("clear2");
        idle();
        set_rd(0, 3);
        tick("x3_cleared");
        chk("x3_zero", bus.rd_data[0 +: XLEN], 64'h0);

        // Reset pulse at clear cycle 10.
        rst_n = 1'b0;
        tick("pre_reset");
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            randomize_inputs();
            tick("clear3");
        end
        rst_n = 1'b0;
        tick("mid_clear_reset");
        rst_n = 1'b1;
        count_to_ready("clear4");

        for (int k = 0; k < 100; k++) begin
            randomize_inputs();
            tick("rand2");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
